// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared period counter and double-buffered period/duty.
// Define PWM_CENTER_ALIGN_EN for an up/down (center-aligned) counter; edge-aligned otherwise.
module pwm_multi #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 21
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [CNT_W-1:0]          period,
    input  logic [CHANNELS*CNT_W-1:0] duty,
    input  logic                      load,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_tick,
    output logic                      pending
);

    logic [CNT_W-1:0]          cnt_reg, cnt_next;
    logic [CNT_W-1:0]          period_act_reg, period_act_next, shadow_period_reg;
    logic [CHANNELS*CNT_W-1:0] duty_act_reg, duty_act_next, shadow_duty_reg;
    logic                      pending_reg, pending_next;
    logic [CHANNELS-1:0]       pwm_reg, pwm_next;
    logic                      tick_reg;
    logic                      boundary;
    logic                      apply_now;

`ifdef PWM_CENTER_ALIGN_EN
    logic dir_down_reg, dir_down_next;

    // The top end only turns the counter around; the period closes at the bottom.
    always_comb begin
        boundary = en && ((period_act_reg == '0) || (dir_down_reg && (cnt_reg == '0)));
    end

    always_comb begin
        cnt_next      = cnt_reg;
        dir_down_next = dir_down_reg;
        if (!en) begin
            cnt_next      = '0;
            dir_down_next = 1'b0;
        end else if (boundary) begin
            dir_down_next = 1'b0;
            cnt_next      = (period_act_next == '0) ? '0 : CNT_W'(1);
        end else if (!dir_down_reg) begin
            if (cnt_reg == period_act_reg) begin
                dir_down_next = 1'b1;
                cnt_next      = cnt_reg - CNT_W'(1);
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end else begin
            cnt_next = cnt_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_down_reg <= 1'b0;
        end else begin
            dir_down_reg <= dir_down_next;
        end
    end
`else
    always_comb begin
        boundary = en && (cnt_reg == period_act_reg);
    end

    always_comb begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (!en || boundary) begin
            cnt_next = '0;
        end
    end
`endif

    // A load landing on an apply cycle goes straight to the active set.
    always_comb begin
        apply_now       = boundary || !en;
        period_act_next = period_act_reg;
        duty_act_next   = duty_act_reg;
        pending_next    = pending_reg;
        if (apply_now) begin
            if (load) begin
                period_act_next = period;
                duty_act_next   = duty;
                pending_next    = 1'b0;
            end else if (pending_reg) begin
                period_act_next = shadow_period_reg;
                duty_act_next   = shadow_duty_reg;
                pending_next    = 1'b0;
            end
        end else if (load) begin
            pending_next = 1'b1;
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_cmp
        assign pwm_next[gi] = en && (cnt_reg < duty_act_reg[gi*CNT_W +: CNT_W]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg           <= '0;
            period_act_reg    <= '0;
            duty_act_reg      <= '0;
            shadow_period_reg <= '0;
            shadow_duty_reg   <= '0;
            pending_reg       <= 1'b0;
            pwm_reg           <= '0;
            tick_reg          <= 1'b0;
        end else begin
            cnt_reg        <= cnt_next;
            period_act_reg <= period_act_next;
            duty_act_reg   <= duty_act_next;
            pending_reg    <= pending_next;
            pwm_reg        <= pwm_next;
            tick_reg       <= boundary;
            if (load) begin
                shadow_period_reg <= period;
                shadow_duty_reg   <= duty;
            end
        end
    end

    assign pwm_out     = pwm_reg;
    assign period_tick = tick_reg;
    assign pending     = pending_reg;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed self-checking bench for pwm_multi (CNT_W=8, CHANNELS=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pwm_multi;
    localparam int CH = 4;
    localparam int W  = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            load;
    logic [W-1:0]    period;
    logic [CH*W-1:0] duty;
    logic [CH-1:0]   pwm_out;
    logic            period_tick;
    logic            pending;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pwm_multi #(.CHANNELS(CH), .CNT_W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .period      (period),
        .duty        (duty),
        .load        (load),
        .pwm_out     (pwm_out),
        .period_tick (period_tick),
        .pending     (pending)
    );

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (period_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wait_tick: got no period_tick within 40 clks, required one");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; load = 1'b1; period = 8'd3; duty = 32'h01020304;
        repeat (3) @(negedge clk);
        checks++;
        if (pwm_out !== 4'b0000) begin
            failures++; $display("FAIL reset_pwm: got %b required 0000", pwm_out);
        end
        checks++;
        if (period_tick !== 1'b0) begin
            failures++; $display("FAIL reset_tick: got %b required 0", period_tick);
        end
        checks++;
        if (pending !== 1'b0) begin
            failures++; $display("FAIL reset_pending: got %b required 0", pending);
        end
        load = 1'b0;
        $display("test_reset: pwm=%b tick=%b pending=%b", pwm_out, period_tick, pending);
    endtask

    task automatic test_duty_pattern();
        int c[CH];
        int t, p;
        t = 0; p = 0;
        for (int i = 0; i < CH; i++) c[i] = 0;
        @(negedge clk);
        rst = 1'b0; en = 1'b0; load = 1'b1; period = 8'd9; duty = {8'd12, 8'd5, 8'd3, 8'd0};
        @(negedge clk);
        load = 1'b0; en = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            for (int i = 0; i < CH; i++) c[i] += int'(pwm_out[i]);
            t += int'(period_tick);
            p += int'(pending);
        end
        checks++;
        if (c[0] != 0)  begin failures++; $display("FAIL duty_ch0: got %0d high clks required 0", c[0]); end
        checks++;
        if (c[1] != 6)  begin failures++; $display("FAIL duty_ch1: got %0d high clks required 6", c[1]); end
        checks++;
        if (c[2] != 10) begin failures++; $display("FAIL duty_ch2: got %0d high clks required 10", c[2]); end
        checks++;
        if (c[3] != 20) begin failures++; $display("FAIL duty_ch3: got %0d high clks required 20", c[3]); end
        checks++;
        if (t != 2)     begin failures++; $display("FAIL duty_ticks: got %0d ticks required 2", t); end
        checks++;
        if (p != 0)     begin failures++; $display("FAIL duty_pending: got %0d pending clks required 0", p); end
        $display("test_duty_pattern: highs=%0d/%0d/%0d/%0d ticks=%0d over 20 clks", c[0], c[1], c[2], c[3], t);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int np, hi1_before, hi1, hi2;
        np = 0; hi1_before = 0; hi1 = 0; hi2 = 0;
        wait_tick(ok);
        repeat (4) @(negedge clk);
        load = 1'b1; duty = {8'd12, 8'd5, 8'd6, 8'd0};
        @(negedge clk);
        duty = {8'd12, 8'd5, 8'd7, 8'd0};
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (pending !== 1'b1) begin failures++; $display("FAIL b2b_pending_set: got %b required 1", pending); end
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (period_tick === 1'b1) begin ok = 1'b1; break; end
            np += int'(pending);
            hi1_before += int'(pwm_out[1]);
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL b2b_tick: got no boundary tick required one"); end
        checks++;
        if (np != 3) begin failures++; $display("FAIL b2b_pending_len: got %0d clks required 3", np); end
        checks++;
        if (pending !== 1'b0) begin failures++; $display("FAIL b2b_pending_clr: got %b required 0", pending); end
        checks++;
        if (hi1_before != 0) begin failures++; $display("FAIL b2b_old_duty: got %0d high clks required 0", hi1_before); end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            hi1 += int'(pwm_out[1]);
            hi2 += int'(pwm_out[2]);
        end
        checks++;
        if (hi1 != 7) begin failures++; $display("FAIL b2b_new_duty_ch1: got %0d high clks required 7", hi1); end
        checks++;
        if (hi2 != 5) begin failures++; $display("FAIL b2b_ch2_kept: got %0d high clks required 5", hi2); end
        $display("test_back_to_back: pending_clks=%0d ch1_high=%0d ch2_high=%0d", np, hi1, hi2);
    endtask

    task automatic test_boundary_load();
        bit ok;
        int c[CH];
        int t, p;
        bit last_tick;
        t = 0; p = 0; last_tick = 1'b0;
        for (int i = 0; i < CH; i++) c[i] = 0;
        wait_tick(ok);
        repeat (9) @(negedge clk);
        load = 1'b1; period = 8'd4; duty = {8'd12, 8'd4, 8'd2, 8'd0};
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (period_tick !== 1'b1) begin failures++; $display("FAIL bnd_tick: got %b required 1", period_tick); end
        checks++;
        if (pending !== 1'b0) begin failures++; $display("FAIL bnd_pending_now: got %b required 0", pending); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            for (int i = 0; i < CH; i++) c[i] += int'(pwm_out[i]);
            t += int'(period_tick);
            p += int'(pending);
            last_tick = period_tick;
        end
        checks++;
        if (c[0] != 0) begin failures++; $display("FAIL bnd_ch0: got %0d required 0", c[0]); end
        checks++;
        if (c[1] != 2) begin failures++; $display("FAIL bnd_ch1: got %0d required 2", c[1]); end
        checks++;
        if (c[2] != 4) begin failures++; $display("FAIL bnd_ch2: got %0d required 4", c[2]); end
        checks++;
        if (c[3] != 5) begin failures++; $display("FAIL bnd_ch3: got %0d required 5", c[3]); end
        checks++;
        if (t != 1 || last_tick !== 1'b1) begin
            failures++; $display("FAIL bnd_period5: got ticks=%0d last=%b required ticks=1 last=1", t, last_tick);
        end
        checks++;
        if (p != 0) begin failures++; $display("FAIL bnd_pending: got %0d clks required 0", p); end
        $display("test_boundary_load: highs=%0d/%0d/%0d/%0d ticks=%0d", c[0], c[1], c[2], c[3], t);
    endtask

    task automatic test_period_zero();
        int good_pwm, t;
        good_pwm = 0; t = 0;
        @(negedge clk);
        en = 1'b0; load = 1'b1; period = 8'd0; duty = {8'd0, 8'd0, 8'd0, 8'd1};
        @(negedge clk);
        load = 1'b0; en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (pwm_out === 4'b0001) good_pwm++;
            t += int'(period_tick);
        end
        checks++;
        if (good_pwm != 8) begin failures++; $display("FAIL p0_pwm: got %0d clks at 0001 required 8", good_pwm); end
        checks++;
        if (t != 8) begin failures++; $display("FAIL p0_ticks: got %0d required 8", t); end
        en = 1'b0;
        @(negedge clk);
        checks++;
        if (pwm_out !== 4'b0000) begin failures++; $display("FAIL p0_en_off_pwm: got %b required 0000", pwm_out); end
        checks++;
        if (period_tick !== 1'b0) begin failures++; $display("FAIL p0_en_off_tick: got %b required 0", period_tick); end
        $display("test_period_zero: pwm_ok=%0d ticks=%0d", good_pwm, t);
    endtask

    task automatic test_reset_midperiod();
        int nz, p, hi1, hi3, t;
        bit last_tick;
        nz = 0; p = 0; hi1 = 0; hi3 = 0; t = 0; last_tick = 1'b0;
        @(negedge clk);
        en = 1'b0; load = 1'b1; period = 8'd9; duty = {8'd12, 8'd5, 8'd3, 8'd0};
        @(negedge clk);
        load = 1'b0; en = 1'b1;
        repeat (2) @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (pending !== 1'b1) begin failures++; $display("FAIL rstm_pending_pre: got %b required 1", pending); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (pwm_out !== 4'b0000 || period_tick !== 1'b0 || pending !== 1'b0) begin
            failures++;
            $display("FAIL rstm_clear: got pwm=%b tick=%b pending=%b required 0000/0/0", pwm_out, period_tick, pending);
        end
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (pwm_out !== 4'b0000) nz++;
            p += int'(pending);
        end
        checks++;
        if (nz != 0) begin failures++; $display("FAIL rstm_idle_pwm: got %0d non-zero clks required 0", nz); end
        checks++;
        if (p != 0) begin failures++; $display("FAIL rstm_idle_pending: got %0d clks required 0", p); end
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            hi1 += int'(pwm_out[1]);
            hi3 += int'(pwm_out[3]);
            t += int'(period_tick);
            last_tick = period_tick;
        end
        checks++;
        if (hi1 != 3 || hi3 != 10) begin
            failures++; $display("FAIL rstm_restart_duty: got ch1=%0d ch3=%0d required 3/10", hi1, hi3);
        end
        checks++;
        if (t != 1 || last_tick !== 1'b1) begin
            failures++; $display("FAIL rstm_restart_tick: got ticks=%0d last=%b required 1/1", t, last_tick);
        end
        $display("test_reset_midperiod: ch1=%0d ch3=%0d ticks=%0d", hi1, hi3, t);
    endtask

`ifdef PWM_CENTER_ALIGN_EN
    task automatic test_center();
        bit ok;
        int c0, other, t, gap;
        c0 = 0; other = 0; t = 0; gap = 0;
        @(negedge clk);
        rst = 1'b0; en = 1'b0; load = 1'b1; period = 8'd5; duty = {8'd0, 8'd0, 8'd0, 8'd2};
        @(negedge clk);
        load = 1'b0; en = 1'b1;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            c0 += int'(pwm_out[0]);
            if (pwm_out[3:1] !== 3'b000) other++;
            t += int'(period_tick);
        end
        checks++;
        if (c0 != 6) begin failures++; $display("FAIL ctr_ch0: got %0d high clks required 6", c0); end
        checks++;
        if (other != 0) begin failures++; $display("FAIL ctr_others: got %0d clks required 0", other); end
        checks++;
        if (t != 2) begin failures++; $display("FAIL ctr_ticks: got %0d required 2", t); end
        wait_tick(ok);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            gap++;
            if (period_tick === 1'b1) break;
        end
        checks++;
        if (gap != 10) begin failures++; $display("FAIL ctr_period: got %0d clks required 10", gap); end
        $display("test_center: ch0_high=%0d ticks=%0d period=%0d", c0, t, gap);
    endtask
`endif

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; period = '0; duty = '0;
        test_reset();
`ifdef PWM_CENTER_ALIGN_EN
        test_center();
`else
        test_duty_pattern();
        test_back_to_back();
        test_boundary_load();
        test_period_zero();
        test_reset_midperiod();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
